// File: rtl/ks16_pkg.sv
// ks16_pkg: shared op codes, FSM states and word width for the 16-bit multi-word datapath
package ks16_pkg;
  localparam int WORD_W = 16;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/koggestone16.sv
// koggestone16: 16-bit Kogge-Stone adder with carry-in, carry-out and carry into bit 15
module koggestone16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout,
  output logic        o_c15
);
  logic [15:0] w_g [5];
  logic [15:0] w_p [4];
  logic [15:0] w_c;
  // carry-in folded into bit 0 generate so the prefix tree yields all carries directly
  assign w_p[0] = i_a ^ i_b;
  assign w_g[0] = {i_a[15:1] & i_b[15:1], (i_a[0] & i_b[0]) | (w_p[0][0] & i_cin)};
  genvar l, i;
  generate
    for (l = 0; l < 4; l++) begin : g_lvl
      for (i = 0; i < 16; i++) begin : g_bit
        if (i >= (1 << l)) begin : g_mix
          assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-(1<<l)]);
          if (l < 3) begin : g_p
            assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
          end
        end else begin : g_pass
          assign w_g[l+1][i] = w_g[l][i];
          if (l < 3) begin : g_p
            assign w_p[l+1][i] = w_p[l][i];
          end
        end
      end
    end
  endgenerate
  assign w_c    = {w_g[4][14:0], i_cin};
  assign o_sum  = w_p[0] ^ w_c;
  assign o_cout = w_g[4][15];
  assign o_c15  = w_g[4][14];
endmodule

// File: rtl/xor16.sv
// xor16: 16-bit bitwise XOR slice
module xor16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

// File: rtl/ks16_mw_seq.sv
// ks16_mw_seq: runs a WORDS x 16-bit ADD/SUB/XOR through one shared 16-bit slice, LSW first
module ks16_mw_seq
  import ks16_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] A,
  input  logic [WORDS*WORD_W-1:0] B,
  input  logic [1:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] S,
  output logic                    cout,
  output logic                    ovf
);
  localparam int W  = WORDS * WORD_W;
  localparam int IW = $clog2(WORDS);
  state_t             r_state, w_next;
  logic [W-1:0]       r_a, r_b, r_s, w_binv;
  logic [1:0]         r_op;
  logic [IW-1:0]      r_idx;
  logic               r_carry, r_cout, r_ovf;
  logic [WORD_W-1:0]  w_sum, w_xor, w_word;
  logic               w_co, w_c15, w_is_xor, w_last, w_accept;
  genvar i;
  // SUB operand inversion: each B word XORed with all-ones at acceptance
  generate
    for (i = 0; i < WORDS; i++) begin : g_inv
      xor16 u_inv (
        .i_a(B[i*WORD_W +: WORD_W]),
        .i_b({WORD_W{op == OP_SUB}}),
        .o_y(w_binv[i*WORD_W +: WORD_W])
      );
    end
  endgenerate
  koggestone16 u_add (
    .i_a(r_a[WORD_W-1:0]),
    .i_b(r_b[WORD_W-1:0]),
    .i_cin(r_carry),
    .o_sum(w_sum),
    .o_cout(w_co),
    .o_c15(w_c15)
  );
  xor16 u_xor (
    .i_a(r_a[WORD_W-1:0]),
    .i_b(r_b[WORD_W-1:0]),
    .o_y(w_xor)
  );
  assign w_is_xor = r_op == OP_XOR;
  assign w_word   = w_is_xor ? w_xor : w_sum;
  assign w_last   = r_idx == IW'(WORDS - 1);
  assign w_accept = (r_state == IDLE) && in_valid;
  assign S        = r_s;
  assign cout     = r_cout;
  assign ovf      = r_ovf;
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next state and handshake outputs
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    w_next    = (r_state == IDLE && in_valid)           ? RUN  :
                (r_state == RUN && w_last)              ? DONE :
                (r_state == DONE && out_ready)          ? IDLE : r_state;
  end
  // operand capture, then one word per cycle: operands shift down, result shifts in from the top
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= w_binv;
      r_op    <= op;
      r_idx   <= '0;
      r_carry <= op == OP_SUB;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> WORD_W;
      r_b     <= r_b >> WORD_W;
      r_s     <= {w_word, r_s[W-1:WORD_W]};
      r_carry <= w_co;
      r_idx   <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) begin
        r_cout <= !w_is_xor && w_co;
        r_ovf  <= !w_is_xor && (w_c15 ^ w_co);
      end
    end
  end
endmodule

// File: tb/tb_ks16_mw_seq.sv
// tb_ks16_mw_seq: directed checks of ks16_mw_seq with WORDS = 4
module tb_ks16_mw_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic [1:0]  op = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] S;
  logic        cout;
  logic        ovf;
  int          n_chk = 0;
  int          n_fail = 0;

  ks16_mw_seq #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] o, input logic [63:0] es, input logic ec, input logic eo);
    A = a; B = b; op = o; in_valid = 1'b1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    A = ~a; B = ~b; op = 2'd3;
    wait_out(tag, 4);
    chk({tag, " S"}, S, es);
    chk({tag, " cout"}, 64'(cout), 64'(ec));
    chk({tag, " ovf"}, 64'(ovf), 64'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    chk({tag, " S held"}, S, es);
  endtask

  initial begin
    tick();
    tick();
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst S", S, 64'd0);
    chk("rst cout", 64'(cout), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("early out_ready", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    run_op("add_ffff", 64'h0000_0000_0000_FFFF, 64'h1, 2'd0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 64'h0, 1'b1, 1'b0);
    run_op("sub_min",  64'h8000_0000_0000_0000, 64'h1, 2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("xor",      64'hAAAA_5555_F0F0_0F0F, 64'hFFFF_FFFF_0000_FFFF, 2'd2, 64'h5555_AAAA_F0F0_F0F0, 1'b0, 1'b0);
    run_op("add_ovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("op3_add",  64'h1, 64'h2, 2'd3, 64'h3, 1'b0, 1'b0);
    run_op("sub_neg",  64'h3, 64'h5, 2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    A = 64'd5; B = 64'd7; op = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("bp1", 4);
    A = 64'd10; B = 64'd3; op = 2'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp S stable", S, 64'd12);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp handshake out_valid", 64'(out_valid), 64'd0);
    chk("bp handshake in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    A = '0; B = '0; op = 2'd2;
    chk("bp second accepted", 64'(in_ready), 64'd0);
    wait_out("bp2", 4);
    chk("bp2 S", S, 64'd7);
    chk("bp2 cout", 64'(cout), 64'd1);
    chk("bp2 ovf", 64'(ovf), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h1; op = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort S", S, 64'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("abort no output", 64'(out_valid), 64'd0);
    run_op("after_rst", 64'h0001_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 2'd0, 64'h0001_0001_0000_0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
